// File: rtl/arena_shrink_ctrl.sv
// ---------------------------------------------------------------------------
// arena_shrink_ctrl
//   Drives the "hurry up" arena shrink. A request from the game timer starts a
//   warning phase of WARN_FRAMES frames. After that the border thickens by one
//   TILE every STEP_FRAMES frames until MAX_LEVEL is reached, and it then holds
//   until the round ends. All timing comes from startOfFrame pulses.
//
// Optional build macro:
//   SHRINK_FLASH_EN - when defined, flash toggles every 8 unpaused frames in
//                     WARN, starting at 1. When undefined, flash is constant 0.
//
// Ports:
//   clk           in   system clock, rising edge
//   reset         in   synchronous active-high reset
//   startOfFrame  in   one-cycle pulse per video frame (time base)
//   hurry_req     in   request to begin the shrink sequence (seen in IDLE only)
//   pause         in   freezes frame counting while high
//   round_end     in   aborts the sequence and returns to IDLE
//   level         out  current shrink level, 0..MAX_LEVEL
//   border_thick  out  registered level*TILE, saturated at 255
//   level_stb     out  one-cycle pulse on each level increment
//   flash         out  border colour-phase select during WARN
//   shrink_active out  high in WARN and SHRINK
//   shrink_done   out  high in HOLD
// ---------------------------------------------------------------------------
module arena_shrink_ctrl #(
    parameter int unsigned WARN_FRAMES = 120,
    parameter int unsigned STEP_FRAMES = 60,
    parameter int unsigned TILE        = 32,
    parameter int unsigned MAX_LEVEL   = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       startOfFrame,
    input  logic       hurry_req,
    input  logic       pause,
    input  logic       round_end,
    output logic [2:0] level,
    output logic [7:0] border_thick,
    output logic       level_stb,
    output logic       flash,
    output logic       shrink_active,
    output logic       shrink_done
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] WARN   = 2'd1;
    localparam logic [1:0] SHRINK = 2'd2;
    localparam logic [1:0] HOLD   = 2'd3;

    localparam int unsigned MAXF = (WARN_FRAMES > STEP_FRAMES) ? WARN_FRAMES : STEP_FRAMES;
    localparam int          CW   = $clog2(MAXF) + 1;

    localparam logic [CW-1:0] WARN_LAST = CW'(WARN_FRAMES - 1);
    localparam logic [CW-1:0] STEP_LAST = CW'(STEP_FRAMES - 1);
    localparam logic [2:0]    LVL_MAX   = 3'(MAX_LEVEL);

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic          frame_tick;
    logic [2:0]    level_inc;

    assign frame_tick    = startOfFrame & ~pause;
    assign level_inc     = level + 3'd1;
    assign shrink_active = (state == WARN) || (state == SHRINK);
    assign shrink_done   = (state == HOLD);

    // Thickness for a given level, clamped rather than wrapped at 8 bits.
    function automatic logic [7:0] thick_of(input logic [2:0] lv);
        int unsigned p;
        p = 32'(lv) * TILE;
        return (p > 32'd255) ? 8'hFF : p[7:0];
    endfunction

    always_ff @(posedge clk) begin
        level_stb <= 1'b0;
        if (reset) begin
            state        <= IDLE;
            cnt          <= '0;
            level        <= '0;
            border_thick <= '0;
        end else if (round_end) begin
            state        <= IDLE;
            cnt          <= '0;
            level        <= '0;
            border_thick <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (hurry_req) begin
                        state <= WARN;
                        cnt   <= '0;
                    end
                end
                WARN: begin
                    if (frame_tick) begin
                        if (cnt == WARN_LAST) begin
                            // A one-level configuration is finished on the first step.
                            state        <= (LVL_MAX == 3'd1) ? HOLD : SHRINK;
                            cnt          <= '0;
                            level        <= 3'd1;
                            border_thick <= thick_of(3'd1);
                            level_stb    <= 1'b1;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                SHRINK: begin
                    if (frame_tick) begin
                        if (cnt == STEP_LAST) begin
                            cnt          <= '0;
                            level        <= level_inc;
                            border_thick <= thick_of(level_inc);
                            level_stb    <= 1'b1;
                            if (level_inc == LVL_MAX)
                                state <= HOLD;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                default: ; // HOLD: static until round_end or reset
            endcase
        end
    end

`ifdef SHRINK_FLASH_EN
    // 3-bit phase kept separately so the toggle does not depend on CW.
    logic [2:0] flash_phase;
    logic       flash_q;

    always_ff @(posedge clk) begin
        if (reset || round_end) begin
            flash_q     <= 1'b0;
            flash_phase <= '0;
        end else if (state == IDLE) begin
            flash_q     <= hurry_req;
            flash_phase <= '0;
        end else if (state == WARN) begin
            if (frame_tick) begin
                flash_phase <= flash_phase + 3'd1;
                if (cnt == WARN_LAST)
                    flash_q <= 1'b0;
                else if (flash_phase == 3'd7)
                    flash_q <= ~flash_q;
            end
        end else begin
            flash_q     <= 1'b0;
            flash_phase <= '0;
        end
    end

    assign flash = flash_q;
`else
    assign flash = 1'b0;
`endif

endmodule

// File: doc/arena_shrink_ctrl.md
ARENA_SHRINK_CTRL -- requirements
Module: arena_shrink_ctrl

Interface
REQ-001 Parameter WARN_FRAMES, default 120, frames spent in warning phase before first shrink step.
REQ-002 Parameter STEP_FRAMES, default 60, frames between successive shrink steps.
REQ-003 Parameter TILE, default 32, pixels added to border thickness per level.
REQ-004 Parameter MAX_LEVEL, default 4, final shrink level (1..7).
REQ-005 clk  in  1  single system clock; all logic rising-edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 startOfFrame  in  1  one-cycle pulse per video frame; sole time base.
REQ-008 hurry_req  in  1  level request from game timer to begin arena shrink.
REQ-009 pause  in  1  freezes all frame counting while high.
REQ-010 round_end  in  1  aborts sequence, returns to IDLE.
REQ-011 level  out  3  current shrink level, 0..MAX_LEVEL.
REQ-012 border_thick  out  8  border thickness in pixels, level*TILE, to the four border drawers.
REQ-013 level_stb  out  1  one-cycle pulse the cycle level increments.
REQ-014 flash  out  1  colour-phase select for border mux during warning.
REQ-015 shrink_active  out  1  high in WARN and SHRINK.
REQ-016 shrink_done  out  1  high in HOLD.

Function
REQ-017 FSM states IDLE, WARN, SHRINK, HOLD; one-hot or binary at implementer's choice.
REQ-018 IDLE->WARN on hurry_req high, next edge; frame counter cleared to 0.
REQ-019 WARN: counter increments on each startOfFrame with pause low; at count WARN_FRAMES-1 plus a further startOfFrame -> SHRINK, level 0->1, level_stb pulse, counter cleared.
REQ-020 SHRINK: counter increments per unpaused startOfFrame; on reaching STEP_FRAMES frames, level increments, level_stb pulses, counter cleared.
REQ-021 Increment that makes level == MAX_LEVEL also transitions SHRINK->HOLD same edge.
REQ-022 HOLD: outputs static; only round_end or reset leaves HOLD (-> IDLE).
REQ-023 hurry_req outside IDLE ignored; level held high in IDLE re-arms only after leaving IDLE (no retrigger until returned to IDLE).
REQ-024 round_end in any state -> IDLE next edge; level, counter, flash cleared; priority over startOfFrame and hurry_req same cycle.
REQ-025 pause high: startOfFrame ignored, state/counter/level frozen; round_end still honoured.
REQ-026 border_thick registered, equal to level*TILE, updated same edge as level; width saturates at 8'hFF (never wraps).
REQ-027 level_stb exactly one clk wide, never asserted in IDLE or HOLD entry from round_end.
REQ-028 Counter width ceil(log2(max(WARN_FRAMES,STEP_FRAMES)))+1 bits; never wraps.

Reset
REQ-029 reset high at an edge: state IDLE, counter 0, level 0, border_thick 0, level_stb 0, flash 0, shrink_active 0, shrink_done 0.
REQ-030 reset overrides round_end, pause, hurry_req; reset mid-sequence discards progress.

Configuration
REQ-031 Macro SHRINK_FLASH_EN defined: in WARN flash toggles every 8 unpaused frames, starting 1 on WARN entry; flash 0 in all other states.
REQ-032 SHRINK_FLASH_EN undefined: flash tied constant 0; no toggle logic synthesised; all other behaviour identical.

Verification
REQ-033 reset 3 cycles, then idle 10 frames -> all outputs 0, state IDLE.
REQ-034 Defaults, hurry_req pulse, 120 frames -> level 1, border_thick 32, single level_stb; after 180 more frames level 4, border_thick 128, shrink_done 1, exactly 4 level_stb total.
REQ-035 pause high for 50 frames mid-WARN -> level 1 arrives 50 frames later than REQ-034 timing.
REQ-036 round_end and startOfFrame same cycle at level 2 in SHRINK -> next cycle level 0, border_thick 0, no level_stb.
REQ-037 hurry_req held high throughout HOLD -> no retrigger; round_end then hurry_req -> WARN re-entered, counter 0.
REQ-038 SHRINK_FLASH_EN defined: flash 1 for frames 0-7 of WARN, 0 for 8-15; undefined: flash always 0.
